// File: rtl/ex_loader_pkg.sv
// ex_loader_pkg: shared types and default geometry for the 1x1-expand
// weight loader.
//   ex_ld_state_t : loader FSM state encoding
//   DEF_*         : default geometry (14-bit values, 16 values/beat,
//                   16 beats/row)
//   ROW_VALUES    : values per memory row at the default geometry
//   ROW_BITS      : bits per memory row at the default geometry
package ex_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ex_ld_state_t;

  localparam int DEF_DATA_WIDTH = 14;
  localparam int DEF_ROW_LENGTH = 16;
  localparam int DEF_NUM_LANES  = 16;
  localparam int DEF_HEIGHT     = 657;
  localparam int DEF_ADDR_WIDTH = 11;

  localparam int ROW_VALUES = DEF_ROW_LENGTH * DEF_NUM_LANES;
  localparam int ROW_BITS   = ROW_VALUES * DEF_DATA_WIDTH;

endpackage

// File: rtl/ex_row_packer.sv
// ex_row_packer: gathers Num_Lanes lane beats into one packed memory row.
//   clk, rst   : clock / asynchronous active-high reset
//   clear      : restart at lane 0 (a partially filled row is abandoned)
//   beat_valid : a beat is accepted this cycle
//   beat_data  : lane payload, Row_Length values of Data_Width bits
//   row_data   : packed row, lane k at [k*Row_Length*Data_Width +: ...]
//   row_full   : the beat accepted this cycle completes the row
module ex_row_packer #(
  parameter int Data_Width = 14,
  parameter int Row_Length = 16,
  parameter int Num_Lanes  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clear,
  input  logic                                      beat_valid,
  input  logic [Row_Length*Data_Width-1:0]          beat_data,
  output logic [Row_Length*Num_Lanes*Data_Width-1:0] row_data,
  output logic                                      row_full
);

  localparam int LANE_W = Row_Length * Data_Width;
  localparam int CNT_W  = (Num_Lanes > 1) ? $clog2(Num_Lanes) : 1;

  logic [CNT_W-1:0]                 lane_cnt_reg;
  logic [Num_Lanes*LANE_W-1:0]      row_buf_reg;

  // Combinational so the FSM can leave FILL on the very edge that
  // captures the last beat.
  assign row_full = beat_valid && (lane_cnt_reg == CNT_W'(Num_Lanes - 1));
  assign row_data = row_buf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_reg <= '0;
    end else if (clear) begin
      lane_cnt_reg <= '0;
    end else if (beat_valid) begin
      if (row_full) lane_cnt_reg <= '0;
      else          lane_cnt_reg <= lane_cnt_reg + 1'b1;
    end
  end

  // One write-enabled slice per lane; only the slice selected by the
  // lane counter updates, so a stalled stream leaves the buffer intact.
  genvar gi;
  generate
    for (gi = 0; gi < Num_Lanes; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row_buf_reg[gi*LANE_W +: LANE_W] <= '0;
        end else if (beat_valid && !clear && (lane_cnt_reg == CNT_W'(gi))) begin
          row_buf_reg[gi*LANE_W +: LANE_W] <= beat_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ex_weight_loader.sv
// ex_weight_loader: streams lane beats into Memory_1x1_EX_bneck rows.
// Accepts 16-value beats (valid/ready), packs Num_Lanes beats into one
// row, then issues a single write strobe per row at consecutive indices.
//   load_start/start_address/row_count : job request, sampled in IDLE
//   in_valid/in_ready/in_data          : lane beat stream
//   mem_en/mem_wr/mem_index/mem_data   : memory write port
//   load_busy/load_done/load_error     : status (done/error are pulses)
// Optional feature macro EX_LOADER_CHECKSUM_EN adds output checksum[31:0],
// the wrapping sum of all accepted values, sign-extended from Data_Width.
module ex_weight_loader
  import ex_loader_pkg::*;
#(
  parameter int Data_Width = DEF_DATA_WIDTH,
  parameter int Row_Length = DEF_ROW_LENGTH,
  parameter int Num_Lanes  = DEF_NUM_LANES,
  parameter int Height     = DEF_HEIGHT,
  parameter int Addr_Width = DEF_ADDR_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load_start,
  input  logic [Addr_Width-1:0]                       start_address,
  input  logic [Addr_Width-1:0]                       row_count,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [Row_Length*Data_Width-1:0]            in_data,
  output logic                                        mem_en,
  output logic                                        mem_wr,
  output logic [Addr_Width-1:0]                       mem_index,
  output logic [Row_Length*Num_Lanes*Data_Width-1:0]  mem_data,
  output logic                                        load_busy,
  output logic                                        load_done,
`ifdef EX_LOADER_CHECKSUM_EN
  output logic [31:0]                                 checksum,
`endif
  output logic                                        load_error
);

  ex_ld_state_t            state_reg, state_next;
  logic [Addr_Width-1:0]   addr_reg;
  logic [Addr_Width-1:0]   row_cnt_reg;
  logic [Addr_Width-1:0]   row_count_reg;
  logic                    load_error_reg;

  logic                    accept;
  logic                    packer_clear;
  logic                    row_full;
  logic [Addr_Width:0]     end_addr;
  logic                    range_err;
  logic                    start_ok;
  logic                    last_row;

  // One extra bit so start_address + row_count cannot wrap past Height.
  assign end_addr  = {1'b0, start_address} + {1'b0, row_count};
  assign range_err = end_addr > (Addr_Width+1)'(Height);
  assign start_ok  = (state_reg == ST_IDLE) && load_start && !range_err;
  assign last_row  = ({1'b0, row_cnt_reg} + 1'b1) == {1'b0, row_count_reg};

  // in_ready comes from the registered state only.
  assign in_ready  = (state_reg == ST_FILL);
  assign accept    = in_ready && in_valid;

  ex_row_packer #(
    .Data_Width (Data_Width),
    .Row_Length (Row_Length),
    .Num_Lanes  (Num_Lanes)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .beat_valid (accept),
    .beat_data  (in_data),
    .row_data   (mem_data),
    .row_full   (row_full)
  );

  always_comb begin
    state_next   = state_reg;
    packer_clear = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next   = (row_count == '0) ? ST_DONE : ST_FILL;
          packer_clear = 1'b1;
        end
      end
      ST_FILL: begin
        if (row_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next   = last_row ? ST_DONE : ST_FILL;
        packer_clear = 1'b1;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      row_cnt_reg    <= '0;
      row_count_reg  <= '0;
      load_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_error_reg <= (state_reg == ST_IDLE) && load_start && range_err;
      if (start_ok) begin
        addr_reg      <= start_address;
        row_cnt_reg   <= '0;
        row_count_reg <= row_count;
      end else if (state_reg == ST_WRITE) begin
        addr_reg    <= addr_reg + 1'b1;
        row_cnt_reg <= row_cnt_reg + 1'b1;
      end
    end
  end

  assign mem_en     = (state_reg == ST_WRITE);
  assign mem_wr     = (state_reg == ST_WRITE);
  assign mem_index  = addr_reg;
  assign load_busy  = (state_reg != ST_IDLE);
  assign load_done  = (state_reg == ST_DONE);
  assign load_error = load_error_reg;

`ifdef EX_LOADER_CHECKSUM_EN
  logic [31:0] value_ext [Row_Length];
  logic [31:0] beat_sum;
  logic [31:0] checksum_reg;

  genvar gi;
  generate
    for (gi = 0; gi < Row_Length; gi++) begin : g_ext
      assign value_ext[gi] = {{(32-Data_Width){in_data[gi*Data_Width + Data_Width - 1]}},
                              in_data[gi*Data_Width +: Data_Width]};
    end
  endgenerate

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < Row_Length; i++) beat_sum = beat_sum + value_ext[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           checksum_reg <= '0;
    else if (start_ok) checksum_reg <= '0;
    else if (accept)   checksum_reg <= checksum_reg + beat_sum;
  end

  assign checksum = checksum_reg;
`endif

endmodule
